// File: rtl/io_mailbox.sv
// CPU <-> device byte mailbox: a TX FIFO fed by CPU IO writes and an RX FIFO
// drained by CPU IO reads, with a status byte on a second IO port slot.

module io_mailbox_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] w_rd_ptr_inc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [7:0]    r_head;
  logic [7:0]    w_head_next;
  logic          w_pop;
  logic          w_push;

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CNT_FULL);
  assign w_pop        = i_pop && !o_empty;
  // A pop on the same edge frees the slot the push fills, so full does not block it.
  assign w_push       = i_push && (!o_full || w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  assign o_head       = r_head;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  // Head is kept in a register so the consumer sees the next entry with no bubble.
  always_comb begin
    w_head_next = r_head;
    if (w_pop) begin
      w_head_next = (r_count == CNT_ONE) ? i_data : r_mem[w_rd_ptr_inc];
    end else if (w_push && o_empty) begin
      w_head_next = i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_head  <= w_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end
endmodule

module io_mailbox #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  logic [7:0] io_data,
  input  logic       io_wr,
  input  logic       rd_sel,
  inout  logic [7:0] io_stat,
  input  logic       st_sel,
  output logic [7:0] dev_tx_data,
  output logic       dev_tx_valid,
  input  logic       dev_tx_ready,
  input  logic [7:0] dev_rx_data,
  input  logic       dev_rx_valid,
  output logic       dev_rx_ready
);
  logic       w_tx_empty;
  logic       w_tx_full;
  logic       w_rx_empty;
  logic       w_rx_full;
  logic [7:0] w_tx_head;
  logic [7:0] w_rx_head;
  logic       r_rd_sel_d;
  logic       r_st_sel_d;
  logic       r_tx_ovf;
  logic       r_rx_udf;
  logic       w_tx_pop;
  logic       w_tx_push;
  logic       w_tx_drop;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic       w_rd_rise;
  logic       w_st_rise;
  logic       w_rx_udf_set;

  assign dev_tx_valid = !w_tx_empty;
  assign dev_tx_data  = w_tx_head;
  assign dev_rx_ready = !w_rx_full;

  assign w_tx_pop     = dev_tx_valid && dev_tx_ready;
  assign w_tx_push    = io_wr && (!w_tx_full || w_tx_pop);
  assign w_tx_drop    = io_wr && w_tx_full && !w_tx_pop;
  assign w_rx_push    = dev_rx_valid && dev_rx_ready;
  assign w_rd_rise    = rd_sel && !r_rd_sel_d;
  assign w_rx_pop     = w_rd_rise && !w_rx_empty;
  assign w_rx_udf_set = w_rd_rise && w_rx_empty;
  assign w_st_rise    = st_sel && !r_st_sel_d;

  // The CPU owns the data bus while writing; otherwise we present the RX head.
  assign io_data = io_wr ? 8'bz : (w_rx_empty ? 8'h00 : w_rx_head);
  // Bit 4 reads 1 while RX holds no data, giving 8'h14 out of reset.
  assign io_stat = {r_rx_udf, r_tx_ovf, w_rx_full, w_rx_empty,
                    w_tx_full, w_tx_empty, 2'b00};

  io_mailbox_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_data  (io_data),
    .o_head  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  io_mailbox_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_data  (dev_rx_data),
    .o_head  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  // Setting events win over a same-edge status read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sel_d <= 1'b0;
      r_st_sel_d <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_rx_udf   <= 1'b0;
    end else begin
      r_rd_sel_d <= rd_sel;
      r_st_sel_d <= st_sel;
      if (w_tx_drop) begin
        r_tx_ovf <= 1'b1;
      end else if (w_st_rise) begin
        r_tx_ovf <= 1'b0;
      end
      if (w_rx_udf_set) begin
        r_rx_udf <= 1'b1;
      end else if (w_st_rise) begin
        r_rx_udf <= 1'b0;
      end
    end
  end
endmodule
